// File: rtl/store_buf_pkg.sv
// store_buf_pkg: shared widths, pointer sizing and entry type for the store buffer.
// STORE_BUF_COALESCE_EN (in store_buffer) enables in-place store coalescing.
package store_buf_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 5;
  localparam int SB_DW    = 32;
  localparam int SB_PW    = $clog2(SB_DEPTH);
  localparam int SB_CW    = SB_PW + 1;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// sb_match: finds the youngest valid buffer entry whose address equals a probe.
// Scan starts at tail-1 and walks back DEPTH slots.
module sb_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0]    addr_i [DEPTH],
  input  logic [DEPTH-1:0] vld_i,
  input  logic [PW-1:0]    tail_i,
  input  logic [AW-1:0]    probe_i,
  output logic             hit_o,
  output logic [PW-1:0]    idx_o
);

  logic          found;
  logic [PW-1:0] j;
  logic [PW-1:0] sel;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      j = tail_i - PW'(k);
      if (!found && vld_i[j] && (addr_i[j] == probe_i)) begin
        found = 1'b1;
        sel   = j;
      end
    end
  end

  assign hit_o = found;
  assign idx_o = sel;

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posts core stores to a single-port memory, loads take priority.
// Define STORE_BUF_COALESCE_EN to merge stores into a matching buffered entry.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST_VALID,
  input  logic [AW-1:0] ST_ADDR,
  input  logic [DW-1:0] ST_DATA,
  output logic          ST_READY,
  input  logic          LD_VALID,
  input  logic [AW-1:0] LD_ADDR,
  output logic [DW-1:0] LD_DATA,
  output logic          EMPTY,
  output logic [AW-1:0] MEM_A,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WD,
  input  logic [DW-1:0] MEM_RD
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             drain, alloc, full;
  logic             ld_hit, coal_hit;
  logic [PW-1:0]    ld_idx;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i] = ent_q[i].addr;
      vld[i]      = {1'b0, PW'(i) - head_q} < cnt_q;
    end
  end

  sb_match #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) u_ld_match (
    .addr_i  (ent_addr),
    .vld_i   (vld),
    .tail_i  (tail_q),
    .probe_i (LD_ADDR),
    .hit_o   (ld_hit),
    .idx_o   (ld_idx)
  );

`ifdef STORE_BUF_COALESCE_EN
  logic          c_hit;
  logic [PW-1:0] c_idx;

  sb_match #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) u_st_match (
    .addr_i  (ent_addr),
    .vld_i   (vld),
    .tail_i  (tail_q),
    .probe_i (ST_ADDR),
    .hit_o   (c_hit),
    .idx_o   (c_idx)
  );

  // a head leaving this edge cannot absorb the store
  assign coal_hit = c_hit & ~(drain & (c_idx == head_q));
`else
  assign coal_hit = 1'b0;
`endif

  assign EMPTY    = (cnt_q == '0);
  assign full     = (cnt_q == FULL);
  assign drain    = ~LD_VALID & ~EMPTY;
  assign ST_READY = ~full | coal_hit;
  assign alloc    = ST_VALID & ST_READY & ~coal_hit;

  assign MEM_WE  = drain;
  assign MEM_A   = drain ? ent_q[head_q].addr : LD_ADDR;
  assign MEM_WD  = ent_q[head_q].data;
  assign LD_DATA = ld_hit ? ent_q[ld_idx].data : MEM_RD;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + CW'(alloc) - CW'(drain);
    if (drain) head_d = head_q + PW'(1);
    if (alloc) tail_d = tail_q + PW'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (alloc) begin
      ent_q[tail_q] <= '{addr: ST_ADDR, data: ST_DATA};
    end
`ifdef STORE_BUF_COALESCE_EN
    else if (ST_VALID & coal_hit) begin
      ent_q[c_idx].data <= ST_DATA;
    end
`endif
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench, program-order store queue model vs DUT.
// Covers reset, forwarding, full stall, wrap, same-cycle load/store, random mix.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ST_VALID = 1'b0;
  logic [4:0]  ST_ADDR = '0;
  logic [31:0] ST_DATA = '0;
  logic        ST_READY;
  logic        LD_VALID = 1'b0;
  logic [4:0]  LD_ADDR = '0;
  logic [31:0] LD_DATA;
  logic        EMPTY;
  logic [4:0]  MEM_A;
  logic        MEM_WE;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;

  store_buffer dut (
    .CLK      (CLK),
    .RST      (RST),
    .ST_VALID (ST_VALID),
    .ST_ADDR  (ST_ADDR),
    .ST_DATA  (ST_DATA),
    .ST_READY (ST_READY),
    .LD_VALID (LD_VALID),
    .LD_ADDR  (LD_ADDR),
    .LD_DATA  (LD_DATA),
    .EMPTY    (EMPTY),
    .MEM_A    (MEM_A),
    .MEM_WE   (MEM_WE),
    .MEM_WD   (MEM_WD),
    .MEM_RD   (MEM_RD)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_val(int i);
    return (i == 7) ? 32'h5 : 32'hC0DE_0000 + 32'(i);
  endfunction

  // memory attached to the DUT port
  logic [31:0] mem_dut [32];
  bit          init_req = 1'b1;

  assign MEM_RD = mem_dut[MEM_A];

  always @(posedge CLK) begin
    if (init_req) begin
      for (int i = 0; i < 32; i++) mem_dut[i] <= init_val(i);
    end else if (MEM_WE) begin
      mem_dut[MEM_A] <= MEM_WD;
    end
  end

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } st_t;

  typedef struct {
    bit          ldv;
    logic [4:0]  la;
    logic [31:0] ld;
    bit          rdy;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          empty;
  } exp_t;

  st_t         pend [$];
  exp_t        exp_q [$];
  logic [31:0] mem_model [32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(logic [4:0] a);
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].a == a) return pend[i].d;
    return mem_model[a];
  endfunction

  // one cycle: drive, predict from model, commit model at the edge
  task automatic cycle(bit sv, logic [4:0] sa, logic [31:0] sd,
                       bit lv, logic [4:0] la);
    exp_t e;
    st_t  s;
    int   hit;
    bit   acc;
    @(negedge CLK);
    RST      = 1'b1;
    ST_VALID = sv;
    ST_ADDR  = sa;
    ST_DATA  = sd;
    LD_VALID = lv;
    LD_ADDR  = la;
    e.ldv   = lv;
    e.la    = la;
    e.ld    = fwd(la);
    e.we    = !lv && (pend.size() > 0);
    e.wa    = '0;
    e.wd    = '0;
    if (e.we) begin
      e.wa = pend[0].a;
      e.wd = pend[0].d;
    end
    e.empty = (pend.size() == 0);
    hit = -1;
`ifdef STORE_BUF_COALESCE_EN
    foreach (pend[i])
      if (pend[i].a == sa && !(e.we && i == 0)) hit = i;
`endif
    e.rdy = (pend.size() < DEPTH) || (hit >= 0);
    exp_q.push_back(e);
    acc = sv && e.rdy;
    @(posedge CLK);
    if (acc && hit >= 0) pend[hit].d = sd;
    if (e.we) begin
      s = pend.pop_front();
      mem_model[s.a] = s.d;
    end
    if (acc && hit < 0) begin
      s.a = sa;
      s.d = sd;
      pend.push_back(s);
    end
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge CLK);
    ST_VALID = 1'b0;
    LD_VALID = 1'b0;
    RST      = 1'b0;
    e = '{ldv: 1'b0, la: '0, ld: '0, rdy: 1'b1, we: 1'b0,
          wa: '0, wd: '0, empty: 1'b1};
    exp_q.push_back(e);
    pend.delete();
    @(posedge CLK);
  endtask

  // monitor: compares whatever the DUT presents against the next expectation
  always @(negedge CLK) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("st_ready", 32'(ST_READY), 32'(e.rdy));
      chk("empty", 32'(EMPTY), 32'(e.empty));
      chk("mem_we", 32'(MEM_WE), 32'(e.we));
      if (e.we) begin
        chk("drain_addr", 32'(MEM_A), 32'(e.wa));
        chk("drain_data", MEM_WD, e.wd);
      end
      if (e.ldv) begin
        chk("load_addr", 32'(MEM_A), 32'(e.la));
        chk("ld_data", LD_DATA, e.ld);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem_model[i] = init_val(i);
    @(posedge CLK);
    #1 init_req = 1'b0;
    do_reset();

    // reset while three stores are pending and the port is draining
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 5'(20 + i), 32'hDEAD_0000 + 32'(i), 1'b1, 5'd9);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd9);
    do_reset();
    repeat (2) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd9);

    // youngest of two stores to the same word is forwarded
    cycle(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd9);
    cycle(1'b1, 5'd3, 32'h2222_2222, 1'b1, 5'd9);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    repeat (3) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd9);

    // fill under load pressure, stall, then in-order drain
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 5'(i), 32'hA0 + 32'(i), 1'b1, 5'd9);
    cycle(1'b1, 5'd4, 32'hFF, 1'b1, 5'd9);
    repeat (5) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd9);

    // pointer wrap with back-to-back store/drain
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 5'(10 + i), 32'hB0 + 32'(i), 1'b0, 5'd9);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd9);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd30);

    // same-cycle load and store to one word returns the old value
    cycle(1'b1, 5'd7, 32'hAAAA_AAAA, 1'b1, 5'd7);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    repeat (2) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd9);

`ifdef STORE_BUF_COALESCE_EN
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 5'(i), 32'hC0 + 32'(i), 1'b1, 5'd9);
    cycle(1'b1, 5'd2, 32'hBEEF, 1'b1, 5'd9);
    cycle(1'b1, 5'd5, 32'hF5, 1'b1, 5'd9);
    repeat (5) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd9);
`endif

    repeat (400) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 9) < 4,
                 5'($urandom_range(0, 7)));
    end

    repeat (DEPTH + 1) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    @(negedge CLK);
    #4;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 32; i++)
      chk($sformatf("mem[%0d]", i), mem_dut[i], mem_model[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-posting stage directly upstream of the data memory. The memory has a single address port, combinational read and synchronous write.
- Accepts word stores from the core's integer and FP store paths into a small FIFO and drains them into the memory one per cycle whenever the port is free.
- Serves loads with priority, forwarding the youngest matching buffered store so the core never observes stale data.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2).
- AW, 5, word-address width (matches the memory's address port).
- DW, 32, data width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- ST_VALID  in  1  core presents a store this cycle.
- ST_ADDR  in  AW  store word address.
- ST_DATA  in  DW  store data (integer or FP register value).
- ST_READY  out  1  store accepted at this edge if ST_VALID=1.
- LD_VALID  in  1  core performs a load this cycle.
- LD_ADDR  in  AW  load word address.
- LD_DATA  out  DW  load result, combinational.
- EMPTY  out  1  no pending stores; used by fence/halt logic.
- MEM_A  out  AW  memory address.
- MEM_WE  out  1  memory write enable.
- MEM_WD  out  DW  memory write data.
- MEM_RD  in  DW  memory read data.

Behaviour:
- Storage: DEPTH entries {addr, data}, head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, count of log2(DEPTH)+1 bits.
- Reset (RST=0, asynchronous): count=0, head=tail=0. Outputs settle to ST_READY=1, EMPTY=1, MEM_WE=0. Entry contents are don't-care.
- Reset mid-operation: all pending stores are discarded and never written.
- Enqueue: at the edge where ST_VALID & ST_READY, write the entry at tail, tail++ and count++.
  - ST_READY = (count<DEPTH).
  - Full buffer: ST_READY=0, and the core stalls the store instruction.
- Port arbitration is combinational each cycle:
  - LD_VALID=1: MEM_A=LD_ADDR, MEM_WE=0, no drain this cycle.
  - Otherwise, if count>0: MEM_A=head.addr, MEM_WD=head.data, MEM_WE=1. The memory writes at this edge; head++ and count-- at the same edge.
  - Otherwise: MEM_A=LD_ADDR, MEM_WE=0.
- Drain latency: a store accepted at edge N is written to memory at edge N+1 at the earliest, when no load occupies the port.
- Forwarding:
  - LD_DATA = data of the youngest valid entry with addr==LD_ADDR; MEM_RD if there is no match.
  - Youngest means closest to tail-1, scanning backward to head.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance. This is legal only when not full, because ST_READY does not consider the drain.
- Simultaneous load and store to the same address in one cycle: the load returns the pre-store value, since the store is not yet in the buffer. This matches single-cycle program order, where a load and a store are never the same instruction.
- EMPTY = (count==0).
- Starvation: back-to-back loads block draining indefinitely; correctness holds via forwarding. Fullness stalls stores, not loads.

Optional Feature:
- Macro STORE_BUF_COALESCE_EN.
- Defined: a store whose ST_ADDR matches a valid entry overwrites that entry's data in place, with no allocation and count unchanged.
  - At most one entry per address exists.
  - ST_READY = (count<DEPTH) | coalesce_hit.
  - If the only match is the head being drained this same cycle, the store allocates a new entry instead; if full, ST_READY=0.
- Undefined: every accepted store allocates, and duplicates are allowed.

Decomposition:
- Package store_buf_pkg: AW/DW defaults, an entry struct typedef {addr, data}, and pointer/count width constants derived from DEPTH.
- One sub-module, sb_match: given the entry array, valid vector, head/tail and a probe address, it returns hit plus the youngest matching index.
  - Instanced for load forwarding.
  - Instanced a second time for coalescing when STORE_BUF_COALESCE_EN is defined.

Test Plan:
1. Reset with RST=0 mid-drain (3 entries pending) → immediately EMPTY=1, ST_READY=1, MEM_WE=0; those addresses are never written after release.
2. Store 0x11111111→addr 3, then 0x22222222→addr 3, then load addr 3 with LD_VALID held → LD_DATA=0x22222222 from the buffer, MEM_WE=0 throughout the load.
3. Four stores (addr 0..3) while LD_VALID=1 continuously → after the 4th, ST_READY=0. Drop LD_VALID → MEM_WE=1 on four consecutive cycles with addr 0,1,2,3 in order, then EMPTY=1.
4. Pointer wrap: 6 stores interleaved with drains (DEPTH=4) → memory holds all 6 values at their addresses; a load of a non-buffered address returns MEM_RD.
5. Load addr 7 and store 0xAAAAAAAA→addr 7 in the same cycle, memory holding 0x5 → LD_DATA=0x5; the next-cycle load returns 0xAAAAAAAA.
6. (COALESCE_EN) Full buffer with addrs 0–3 and LD_VALID=1, store 0xBEEF→addr 2 → ST_READY=1, count stays 4; the later drain writes 0xBEEF to addr 2 exactly once.
